lcd_write_sequencer: RTL and testbench

- Hardware sequencer for the Spartan-3E character LCD in 4-bit mode. It replaces the CPU's software NOP-delay loops around the `LCD` instruction.
- Runs the power-on init sequence after reset.
- Then accepts one byte per request from the CPU's `LCD` execute stage, drives high and low nibbles with correct E/RS timing, and reports ready/done so the CPU stalls instead of spinning.

---
 rtl/lcd_write_sequencer_pkg.sv | 42 ++++
 rtl/lcd_write_sequencer_nibble_tx.sv | 101 ++++++++++
 rtl/lcd_write_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_write_sequencer_pkg.sv
// Shared types, init nibble constants and default 50 MHz timing for the
// Spartan-3E character LCD write sequencer.
package lcd_write_sequencer_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT  = 3'd0,
    INIT_NIB  = 3'd1,
    INIT_WAIT = 3'd2,
    IDLE      = 3'd3,
    HI_NIB    = 3'd4,
    GAP       = 3'd5,
    LO_NIB    = 3'd6,
    POST      = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    NIB_IDLE  = 2'd0,
    NIB_SETUP = 2'd1,
    NIB_PULSE = 2'd2,
    NIB_HOLD  = 2'd3
  } nib_phase_e;

  localparam logic [3:0] INIT_NIBBLE_A = 4'h3;
  localparam logic [3:0] INIT_NIBBLE_B = 4'h2;
  localparam logic [1:0] INIT_LAST     = 2'd3;

  localparam int unsigned DEF_T_SETUP = 2;
  localparam int unsigned DEF_T_PULSE = 12;
  localparam int unsigned DEF_T_HOLD  = 1;
  localparam int unsigned DEF_T_GAP   = 50;
  localparam int unsigned DEF_T_POST  = 2000;
  localparam int unsigned DEF_T_PWR   = 750000;
  localparam int unsigned DEF_T_INIT1 = 205000;
  localparam int unsigned DEF_T_INIT2 = 5000;
  localparam int unsigned DEF_CNT_W   = 20;

  // Terminal count for a duration of t cycles; a zero duration behaves as one.
  function automatic int unsigned cnt_load(input int unsigned t);
    return (t == 32'd0) ? 32'd0 : t - 32'd1;
  endfunction

endpackage

// File: rtl/lcd_write_sequencer_nibble_tx.sv
// One 4-bit LCD transfer: data/RS setup, E pulse, hold. All outputs are
// registered so E is glitch-free; data and RS persist after the transfer.
module lcd_write_sequencer_nibble_tx
  import lcd_write_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_PULSE = DEF_T_PULSE,
  parameter int unsigned T_HOLD  = DEF_T_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       e,
  output logic [3:0] data,
  output logic       rs_out,
  output logic       done
);

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(cnt_load(T_SETUP));
  localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(cnt_load(T_PULSE));
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(cnt_load(T_HOLD));

  nib_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic [3:0]       data_q, data_d;
  logic             rs_q, rs_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    data_d  = data_q;
    rs_d    = rs_q;
    if (start) begin
      phase_d = NIB_SETUP;
      cnt_d   = L_SETUP;
      e_d     = 1'b0;
      data_d  = nibble;
      rs_d    = rs;
    end else begin
      case (phase_q)
        NIB_SETUP: begin
          if (cnt_q == '0) begin
            phase_d = NIB_PULSE;
            cnt_d   = L_PULSE;
            e_d     = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        NIB_PULSE: begin
          if (cnt_q == '0) begin
            phase_d = NIB_HOLD;
            cnt_d   = L_HOLD;
            e_d     = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        NIB_HOLD: begin
          if (cnt_q == '0) begin
            phase_d = NIB_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          phase_d = NIB_IDLE;
          e_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= NIB_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      data_q  <= 4'h0;
      rs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
    end
  end

  // Asserted during the last hold cycle so the owner can move on without a bubble.
  assign done   = (phase_q == NIB_HOLD) && (cnt_q == '0);
  assign e      = e_q;
  assign data   = data_q;
  assign rs_out = rs_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// Power-on init plus byte-write sequencer for the character LCD in 4-bit mode;
// stalls the CPU through oReady instead of software delay loops.
module lcd_write_sequencer
  import lcd_write_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_PULSE = DEF_T_PULSE,
  parameter int unsigned T_HOLD  = DEF_T_HOLD,
  parameter int unsigned T_GAP   = DEF_T_GAP,
  parameter int unsigned T_POST  = DEF_T_POST,
  parameter int unsigned T_PWR   = DEF_T_PWR,
  parameter int unsigned T_INIT1 = DEF_T_INIT1,
  parameter int unsigned T_INIT2 = DEF_T_INIT2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iRS,
  output logic       oReady,
  output logic       oDone,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(cnt_load(T_GAP));
  localparam logic [CNT_W-1:0] L_POST  = CNT_W'(cnt_load(T_POST));
  localparam logic [CNT_W-1:0] L_PWR   = CNT_W'(cnt_load(T_PWR));
  localparam logic [CNT_W-1:0] L_INIT1 = CNT_W'(cnt_load(T_INIT1));
  localparam logic [CNT_W-1:0] L_INIT2 = CNT_W'(cnt_load(T_INIT2));

  function automatic logic [CNT_W-1:0] init_wait(input logic [1:0] idx);
    case (idx)
      2'd0:    return L_INIT1;
      2'd1:    return L_INIT2;
      default: return L_POST;
    endcase
  endfunction

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             init_done_q, init_done_d;
  logic [3:0]       lo_q, lo_d;
  logic             rs_q, rs_d;

  logic             nib_start;
  logic [3:0]       nib_val;
  logic             nib_rs;
  logic             nib_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    init_done_d = init_done_q;
    lo_d        = lo_q;
    rs_d        = rs_q;
    nib_start   = 1'b0;
    nib_val     = lo_q;
    nib_rs      = rs_q;
    case (state_q)
      // The counter comes out of reset at zero, so the power-on wait counts up.
      PWR_WAIT: begin
        if (cnt_q == L_PWR) begin
          state_d   = INIT_NIB;
          cnt_d     = '0;
          idx_d     = 2'd0;
          nib_start = 1'b1;
          nib_val   = INIT_NIBBLE_A;
          nib_rs    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      INIT_NIB: begin
        if (nib_done) begin
          state_d = INIT_WAIT;
          cnt_d   = init_wait(idx_q);
        end
      end
      INIT_WAIT: begin
        if (cnt_q == '0) begin
          if (idx_q == INIT_LAST) begin
            state_d     = IDLE;
            ready_d     = 1'b1;
            init_done_d = 1'b1;
          end else begin
            idx_d     = idx_q + 2'd1;
            state_d   = INIT_NIB;
            nib_start = 1'b1;
            nib_val   = (idx_d == INIT_LAST) ? INIT_NIBBLE_B : INIT_NIBBLE_A;
            nib_rs    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      IDLE: begin
        if (iStart) begin
          state_d   = HI_NIB;
          lo_d      = iData[3:0];
          rs_d      = iRS;
          nib_start = 1'b1;
          nib_val   = iData[7:4];
          nib_rs    = iRS;
        end else begin
          ready_d = 1'b1;
        end
      end
      HI_NIB: begin
        if (nib_done) begin
          state_d = GAP;
          cnt_d   = L_GAP;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d   = LO_NIB;
          nib_start = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LO_NIB: begin
        if (nib_done) begin
          state_d = POST;
          cnt_d   = L_POST;
        end
      end
      POST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d     = PWR_WAIT;
        cnt_d       = '0;
        idx_d       = 2'd0;
        init_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      init_done_q <= init_done_d;
    end
  end

  // The latched byte is only consumed after an accept, so it needs no reset.
  always_ff @(posedge Clock) begin
    lo_q <= lo_d;
    rs_q <= rs_d;
  end

  lcd_write_sequencer_nibble_tx #(
    .CNT_W  (CNT_W),
    .T_SETUP(T_SETUP),
    .T_PULSE(T_PULSE),
    .T_HOLD (T_HOLD)
  ) u_nibble_tx (
    .clk   (Clock),
    .rst_n (Reset),
    .start (nib_start),
    .nibble(nib_val),
    .rs    (nib_rs),
    .e     (oLCD_E),
    .data  (oLCD_Data),
    .rs_out(oLCD_RS),
    .done  (nib_done)
  );

  assign oReady    = ready_q;
  assign oDone     = done_q;
  assign oInitDone = init_done_q;
  assign oLCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer with short timing: a scoreboard of expected
// nibbles checked on every E pulse, plus latency and handshake checks.
module tb_lcd_write_sequencer;

  logic       Clock  = 1'b0;
  logic       Reset  = 1'b0;
  logic       iStart = 1'b0;
  logic [7:0] iData  = 8'h00;
  logic       iRS    = 1'b0;
  logic       oReady, oDone, oInitDone, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_Data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] d;
    logic       rs;
  } nib_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic [3:0] exp_hi;
    logic [3:0] exp_lo;
    int         exp_lat;
  } vec_t;

  nib_t exp_q[$];

  always #5 Clock = ~Clock;

  lcd_write_sequencer #(
    .CNT_W  (20),
    .T_SETUP(2),
    .T_PULSE(3),
    .T_HOLD (1),
    .T_GAP  (4),
    .T_POST (5),
    .T_PWR  (10),
    .T_INIT1(6),
    .T_INIT2(3)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iStart   (iStart),
    .iData    (iData),
    .iRS      (iRS),
    .oReady   (oReady),
    .oDone    (oDone),
    .oInitDone(oInitDone),
    .oLCD_E   (oLCD_E),
    .oLCD_RS  (oLCD_RS),
    .oLCD_RW  (oLCD_RW),
    .oLCD_Data(oLCD_Data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_nib(input logic [3:0] d, input logic rs);
    nib_t n;
    n.d  = d;
    n.rs = rs;
    exp_q.push_back(n);
  endtask

  task automatic push_init();
    push_nib(4'h3, 1'b0);
    push_nib(4'h3, 1'b0);
    push_nib(4'h3, 1'b0);
    push_nib(4'h2, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge Clock);
      #1;
      n++;
    end while (!oReady && n < 300);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge Clock);
      #1;
      n++;
    end while (!oDone && n < 300);
  endtask

  // E-pulse monitor: pops one expected nibble per rising E, checks width on fall.
  logic       e_prev = 1'b0;
  int         width  = 0;
  logic [3:0] rise_d = 4'h0;

  always @(negedge Clock) begin
    if (!Reset) begin
      e_prev <= 1'b0;
      width  <= 0;
    end else begin
      if (oLCD_E && !e_prev) begin
        width  <= 1;
        rise_d <= oLCD_Data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: data=%0h rs=%0b, expected no pulse at %0t",
                   oLCD_Data, oLCD_RS, $time);
        end else begin
          chk("pulse_data", {28'd0, oLCD_Data}, {28'd0, exp_q[0].d});
          chk("pulse_rs", {31'd0, oLCD_RS}, {31'd0, exp_q[0].rs});
          exp_q.delete(0);
        end
      end else if (oLCD_E) begin
        width <= width + 1;
      end else if (e_prev) begin
        chk("pulse_width", width, 32'd3);
        chk("pulse_data_stable", {28'd0, oLCD_Data}, {28'd0, rise_d});
      end
      e_prev <= oLCD_E;
    end
  end

  initial begin
    vec_t tbl[4];
    int   n;
    tbl[0] = '{8'h48, 1'b1, 4'h4, 4'h8, 21};
    tbl[1] = '{8'h01, 1'b0, 4'h0, 4'h1, 21};
    tbl[2] = '{8'hA5, 1'b1, 4'hA, 4'h5, 21};
    tbl[3] = '{8'h80, 1'b0, 4'h8, 4'h0, 21};

    // Reset values
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_ready", oReady, 0);
    chk("rst_done", oDone, 0);
    chk("rst_init_done", oInitDone, 0);
    chk("rst_e", oLCD_E, 0);
    chk("rst_rs", oLCD_RS, 0);
    chk("rst_rw", oLCD_RW, 0);
    chk("rst_data", oLCD_Data, 0);

    // Power-on init with iStart noise that must be ignored
    push_init();
    @(negedge Clock);
    #1 Reset = 1'b1;
    n = 0;
    do begin
      @(posedge Clock);
      #1;
      n++;
      if (n == 5) begin
        iStart = 1'b1;
        iData  = 8'hFF;
        iRS    = 1'b1;
      end
      if (n == 40) iStart = 1'b0;
    end while (!oInitDone && n < 300);
    iStart = 1'b0;
    chk("init_latency", n, 53);
    chk("init_ready", oReady, 1);
    chk("init_nibbles_consumed", exp_q.size(), 0);

    // Table-driven single writes
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      iStart = 1'b1;
      iData  = tbl[i].data;
      iRS    = tbl[i].rs;
      push_nib(tbl[i].exp_hi, tbl[i].rs);
      push_nib(tbl[i].exp_lo, tbl[i].rs);
      @(posedge Clock);
      #1;
      iStart = 1'b0;
      iData  = 8'h00;
      iRS    = ~tbl[i].rs;
      chk("accept_ready_low", oReady, 0);
      wait_ready(n);
      chk("write_latency", n, tbl[i].exp_lat);
      chk("write_done", oDone, 1);
      chk("hold_data", oLCD_Data, tbl[i].exp_lo);
      chk("hold_rs", oLCD_RS, tbl[i].rs);
      chk("rw_zero", oLCD_RW, 0);
      @(posedge Clock);
      #1;
      chk("done_one_cycle", oDone, 0);
    end
    chk("table_nibbles_consumed", exp_q.size(), 0);

    // Back-to-back writes with iStart held high
    @(negedge Clock);
    iStart = 1'b1;
    iData  = 8'h01;
    iRS    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_nib(4'h0, 1'b0);
      push_nib(4'h1, 1'b0);
    end
    @(posedge Clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge Clock);
        #1;
        chk("b2b_reaccept", oReady, 0);
        chk("b2b_done_drop", oDone, 0);
      end
      wait_done(n);
      chk("b2b_period", n, 21);
      chk("b2b_ready_with_done", oReady, 1);
      if (k == 2) iStart = 1'b0;
    end
    @(posedge Clock);
    #1;
    chk("b2b_no_extra_accept", oReady, 1);
    chk("b2b_nibbles_consumed", exp_q.size(), 0);

    // Request during a busy write is dropped
    @(negedge Clock);
    iStart = 1'b1;
    iData  = 8'h5A;
    iRS    = 1'b1;
    push_nib(4'h5, 1'b1);
    push_nib(4'hA, 1'b1);
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    repeat (8) @(posedge Clock);
    #1;
    iStart = 1'b1;
    iData  = 8'hFF;
    iRS    = 1'b0;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    wait_ready(n);
    chk("busy_latency", n + 9, 21);
    chk("busy_hold_data", oLCD_Data, 4'hA);
    chk("busy_hold_rs", oLCD_RS, 1);
    @(posedge Clock);
    #1;
    chk("busy_not_queued", oReady, 1);
    chk("busy_nibbles_consumed", exp_q.size(), 0);

    // Reset asserted while E is high
    @(negedge Clock);
    iStart = 1'b1;
    iData  = 8'h3C;
    iRS    = 1'b0;
    push_nib(4'h3, 1'b0);
    push_nib(4'hC, 1'b0);
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    n = 0;
    while (!oLCD_E && n < 100) begin
      @(negedge Clock);
      n++;
    end
    chk("reached_pulse", oLCD_E, 1);
    #2 Reset = 1'b0;
    #1;
    chk("async_e_low", oLCD_E, 0);
    chk("async_ready_low", oReady, 0);
    chk("async_init_done_low", oInitDone, 0);
    chk("async_data_low", oLCD_Data, 0);
    exp_q.delete();
    push_init();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1 Reset = 1'b1;
    n = 0;
    do begin
      @(posedge Clock);
      #1;
      n++;
    end while (!oInitDone && n < 300);
    chk("reinit_latency", n, 53);
    chk("reinit_ready", oReady, 1);
    chk("reinit_nibbles_consumed", exp_q.size(), 0);

    repeat (5) @(posedge Clock);
    #1;
    chk("final_no_stray_pulses", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
